// File: rtl/ycbcr_skin_threshold_pipe_if.sv
// rtl/ycbcr_skin_threshold_pipe_if.sv - config, video and stats signal bundle for the skin classifier
interface ycbcr_skin_threshold_pipe_if #(
  parameter int DATA_W  = 8,
  parameter int COORD_W = 12,
  parameter int CNT_W   = 22
);
  logic                cfg_we;
  logic [2:0]          cfg_addr;
  logic [DATA_W-1:0]   cfg_wdata;

  logic [DATA_W-1:0]   y;
  logic [DATA_W-1:0]   cb;
  logic [DATA_W-1:0]   cr;
  logic                de_in;
  logic                hdmi_hs_in;
  logic                hdmi_vs_in;

  logic                de_out;
  logic                hdmi_hs_out;
  logic                hdmi_vs_out;
  logic [DATA_W-1:0]   r_out;
  logic [DATA_W-1:0]   g_out;
  logic [DATA_W-1:0]   b_out;

  logic [CNT_W-1:0]    match_count;
  logic [COORD_W-1:0]  x_min;
  logic [COORD_W-1:0]  x_max;
  logic [COORD_W-1:0]  y_min;
  logic [COORD_W-1:0]  y_max;
  logic                stats_valid;

  modport master (
    output cfg_we, cfg_addr, cfg_wdata,
    output y, cb, cr, de_in, hdmi_hs_in, hdmi_vs_in,
    input  de_out, hdmi_hs_out, hdmi_vs_out, r_out, g_out, b_out,
    input  match_count, x_min, x_max, y_min, y_max, stats_valid
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_wdata,
    input  y, cb, cr, de_in, hdmi_hs_in, hdmi_vs_in,
    output de_out, hdmi_hs_out, hdmi_vs_out, r_out, g_out, b_out,
    output match_count, x_min, x_max, y_min, y_max, stats_valid
  );
endinterface

// File: rtl/ycbcr_skin_threshold_pipe.sv
// rtl/ycbcr_skin_threshold_pipe.sv - two-stage Cb/Cr window classifier with per-frame match stats
module ycbcr_skin_threshold_pipe #(
  parameter int          DATA_W     = 8,
  parameter int          COORD_W    = 12,
  parameter int          CNT_W      = 22,
  parameter logic [7:0]  CB_LO_INIT = 8'd90,
  parameter logic [7:0]  CB_HI_INIT = 8'd200,
  parameter logic [7:0]  CR_LO_INIT = 8'd115,
  parameter logic [7:0]  CR_HI_INIT = 8'd200,
  parameter bit          VS_POL     = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  ycbcr_skin_threshold_pipe_if.slave bus
);
  localparam logic [DATA_W-1:0]  D_ONES = '1;
  localparam logic [COORD_W-1:0] C_ONES = '1;
  localparam logic [CNT_W-1:0]   N_ONES = '1;

  logic [DATA_W-1:0]  stg_cb_lo, stg_cb_hi, stg_cr_lo, stg_cr_hi;
  logic [DATA_W-1:0]  act_cb_lo, act_cb_hi, act_cr_lo, act_cr_hi;
  logic               stg_mode, act_mode;

  logic               vs_act, vs_d, vs_edge, de_d, armed;
  logic [COORD_W-1:0] x_cnt, y_cnt;

  logic [DATA_W-1:0]  s1_y;
  logic               s1_match, s1_de, s1_hs, s1_vs;
  logic [COORD_W-1:0] s1_x, s1_yc;

  logic [CNT_W-1:0]   acc_count;
  logic [COORD_W-1:0] acc_xmin, acc_xmax, acc_ymin, acc_ymax;

  logic               de_q, hs_q, vs_q, sv_q;
  logic [DATA_W-1:0]  rgb_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [COORD_W-1:0] xmin_q, xmax_q, ymin_q, ymax_q;

  logic               pix_match, hit;
  logic [DATA_W-1:0]  pix_val;

  assign vs_act  = (bus.hdmi_vs_in == VS_POL);
  assign vs_edge = vs_act & ~vs_d;

  // Strict window; an inverted or empty window (lo >= hi) can never satisfy both sides.
  assign pix_match = (bus.cb > act_cb_lo) && (bus.cb < act_cb_hi) &&
                     (bus.cr > act_cr_lo) && (bus.cr < act_cr_hi);

  assign hit = s1_de & s1_match;

  always_comb begin
    pix_val = '0;
    if (s1_de && s1_match) pix_val = act_mode ? s1_y : D_ONES;
  end

  // Staging is always writable; active only follows staging at a frame boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      stg_cb_lo <= CB_LO_INIT[DATA_W-1:0];
      stg_cb_hi <= CB_HI_INIT[DATA_W-1:0];
      stg_cr_lo <= CR_LO_INIT[DATA_W-1:0];
      stg_cr_hi <= CR_HI_INIT[DATA_W-1:0];
      stg_mode  <= 1'b0;
      act_cb_lo <= CB_LO_INIT[DATA_W-1:0];
      act_cb_hi <= CB_HI_INIT[DATA_W-1:0];
      act_cr_lo <= CR_LO_INIT[DATA_W-1:0];
      act_cr_hi <= CR_HI_INIT[DATA_W-1:0];
      act_mode  <= 1'b0;
    end else begin
      if (bus.cfg_we) begin
        case (bus.cfg_addr)
          3'd0:    stg_cb_lo <= bus.cfg_wdata;
          3'd1:    stg_cb_hi <= bus.cfg_wdata;
          3'd2:    stg_cr_lo <= bus.cfg_wdata;
          3'd3:    stg_cr_hi <= bus.cfg_wdata;
          3'd4:    stg_mode  <= bus.cfg_wdata[0];
          default: ;
        endcase
      end
      if (vs_edge) begin
        act_cb_lo <= stg_cb_lo;
        act_cb_hi <= stg_cb_hi;
        act_cr_lo <= stg_cr_lo;
        act_cr_hi <= stg_cr_hi;
        act_mode  <= stg_mode;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vs_d  <= 1'b0;
      de_d  <= 1'b0;
      x_cnt <= '0;
      y_cnt <= '0;
    end else begin
      vs_d <= vs_act;
      de_d <= bus.de_in;
      if (!bus.de_in)         x_cnt <= '0;
      else if (x_cnt != C_ONES) x_cnt <= x_cnt + 1'b1;
      if (vs_edge)            y_cnt <= '0;
      else if (de_d && !bus.de_in && y_cnt != C_ONES) y_cnt <= y_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_y     <= '0;
      s1_match <= 1'b0;
      s1_de    <= 1'b0;
      s1_hs    <= 1'b0;
      s1_vs    <= 1'b0;
      s1_x     <= '0;
      s1_yc    <= '0;
      de_q     <= 1'b0;
      hs_q     <= 1'b0;
      vs_q     <= 1'b0;
      rgb_q    <= '0;
    end else begin
      s1_y     <= bus.y;
      s1_match <= pix_match;
      s1_de    <= bus.de_in;
      s1_hs    <= bus.hdmi_hs_in;
      s1_vs    <= bus.hdmi_vs_in;
      s1_x     <= x_cnt;
      s1_yc    <= y_cnt;
      de_q     <= s1_de;
      hs_q     <= s1_hs;
      vs_q     <= s1_vs;
      rgb_q    <= pix_val;
    end
  end

  // At the boundary the stage-1 pixel seeds the new frame rather than closing the old one.
  always_ff @(posedge clk) begin
    if (rst) begin
      armed     <= 1'b0;
      sv_q      <= 1'b0;
      cnt_q     <= '0;
      xmin_q    <= '0;
      xmax_q    <= '0;
      ymin_q    <= '0;
      ymax_q    <= '0;
      acc_count <= '0;
      acc_xmin  <= C_ONES;
      acc_xmax  <= '0;
      acc_ymin  <= C_ONES;
      acc_ymax  <= '0;
    end else begin
      sv_q <= 1'b0;
      if (vs_edge) begin
        armed <= 1'b1;
        if (armed) begin
          sv_q  <= 1'b1;
          cnt_q <= acc_count;
          if (acc_count == '0) begin
            xmin_q <= '0;
            xmax_q <= '0;
            ymin_q <= '0;
            ymax_q <= '0;
          end else begin
            xmin_q <= acc_xmin;
            xmax_q <= acc_xmax;
            ymin_q <= acc_ymin;
            ymax_q <= acc_ymax;
          end
        end
        acc_count <= hit ? {{(CNT_W-1){1'b0}}, 1'b1} : '0;
        acc_xmin  <= hit ? s1_x  : C_ONES;
        acc_xmax  <= hit ? s1_x  : '0;
        acc_ymin  <= hit ? s1_yc : C_ONES;
        acc_ymax  <= hit ? s1_yc : '0;
      end else if (hit) begin
        if (acc_count != N_ONES) acc_count <= acc_count + 1'b1;
        if (s1_x  < acc_xmin) acc_xmin <= s1_x;
        if (s1_x  > acc_xmax) acc_xmax <= s1_x;
        if (s1_yc < acc_ymin) acc_ymin <= s1_yc;
        if (s1_yc > acc_ymax) acc_ymax <= s1_yc;
      end
    end
  end

  assign bus.de_out      = de_q;
  assign bus.hdmi_hs_out = hs_q;
  assign bus.hdmi_vs_out = vs_q;
  assign bus.r_out       = rgb_q;
  assign bus.g_out       = rgb_q;
  assign bus.b_out       = rgb_q;
  assign bus.match_count = cnt_q;
  assign bus.x_min       = xmin_q;
  assign bus.x_max       = xmax_q;
  assign bus.y_min       = ymin_q;
  assign bus.y_max       = ymax_q;
  assign bus.stats_valid = sv_q;
endmodule

// File: doc/ycbcr_skin_threshold_pipe.md
Name: ycbcr_skin_threshold_pipe

Overview:
- Pipelined, programmable Cb/Cr window classifier for the HDMI video path.
- Produces a binary or luma-gated mask on r/g/b, with sync/DE delayed to match.
- Accumulates per-frame match count and bounding box for the downstream tracking logic.
- Window limits are written via a simple config port and applied only at frame boundaries, so no frame is ever split across two threshold sets.

Parameters:
- DATA_W, 8, pixel component width (y/cb/cr/rgb).
- COORD_W, 12, width of x/y pixel coordinate counters and bbox outputs.
- CNT_W, 22, width of the per-frame match counter (saturating).
- CB_LO_INIT, 90, reset value of Cb lower bound (exclusive).
- CB_HI_INIT, 200, reset value of Cb upper bound (exclusive).
- CR_LO_INIT, 115, reset value of Cr lower bound (exclusive).
- CR_HI_INIT, 200, reset value of Cr upper bound (exclusive).
- VS_POL, 1, active level of hdmi_vs_in.

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous active-high reset
- cfg_we  in  1  config write strobe
- cfg_addr  in  3  0=cb_lo 1=cb_hi 2=cr_lo 3=cr_hi 4=mode; 5-7 ignored
- cfg_wdata  in  DATA_W  config data; mode uses bit0 only
- y, cb, cr  in  DATA_W each  input pixel
- de_in, hdmi_hs_in, hdmi_vs_in  in  1 each  input timing
- de_out, hdmi_hs_out, hdmi_vs_out  out  1 each  timing delayed 2 cycles
- r_out, g_out, b_out  out  DATA_W each  mask pixel
- match_count  out  CNT_W  matched pixels in last complete frame
- x_min, x_max, y_min, y_max  out  COORD_W each  bounding box of last complete frame
- stats_valid  out  1  one-cycle pulse when stats outputs update

Behaviour:
- Register sets:
  - Staging regs are written on cfg_we at cfg_addr.
  - Active regs load from staging on the VS active edge: hdmi_vs_in goes to VS_POL, detected against a registered copy.
  - A write in the same cycle as the edge lands in staging only; it takes effect the following frame.
- Match condition uses active regs with strict compares, all unsigned:
  - cb > cb_lo and cb < cb_hi and cr > cr_lo and cr < cr_hi.
  - lo >= hi never matches.
- Pipeline, fixed latency 2:
  - Stage 1 registers y, the match bit, de, hs and vs.
  - Stage 2 drives the outputs.
  - Every input sample affects its outputs exactly 2 clk later; there is no stall.
- Output mux, stage 2:
  - mode=0: r=g=b = all ones if match, else 0.
  - mode=1: r=g=b = y if match, else 0.
  - When delayed de=0, r/g/b are forced to 0 regardless of match.
- Coordinates, on the input side:
  - x increments on each de_in=1 cycle and clears when de_in=0.
  - y increments on each de_in falling edge and clears on the VS active edge.
  - Both saturate at all ones.
- Accumulators, updated per stage-1 pixel with de=1 and match=1:
  - count += 1, saturating at 2^CNT_W-1.
  - xmin/xmax/ymin/ymax take the min/max against the pixel's coordinates; coordinates are pipelined alongside the match bit.
- Frame end (VS active edge):
  - Accumulators copy to the output regs and stats_valid pulses for 1 cycle.
  - The accumulators restart: count=0, min=all ones, max=0.
  - If count was 0, all four bbox outputs are 0.
  - A pixel arriving at stage 1 in the edge cycle goes into the new frame.
- First VS edge after reset:
  - The accumulated partial frame is discarded and stats_valid is suppressed (armed flag).
  - The active regs still load on that edge.
- Reset values:
  - All outputs 0, including de_out, hs_out, vs_out, stats_valid and stats.
  - Staging and active regs = *_INIT; mode=0.
  - Coordinates and accumulators cleared; edge detector and armed flag cleared.
  - Reset mid-frame aborts the frame; the pipeline contents are dropped.

Test Plan:
- Defaults, mode 0: drive de=1 with (cb,cr) = (91,116), (90,116), (199,199), (200,150), then de=0. Required: r/g/b = FF,00,FF,00 two cycles later; de/hs/vs delayed exactly 2 cycles.
- Mode 1: write mode=1 mid-frame, y=0x55, cb=100, cr=150. Required: output stays the binary FF until the next VS edge, then becomes 0x55 per match; non-match gives 0.
- Config race: write cb_lo=150 in the same cycle as a VS edge. Required: the next frame still uses 90; the frame after uses 150.
- Stats: 4-line x 8-pixel frame with matches only at (x=2,y=1) and (x=5,y=3). Required: at the following VS edge stats_valid=1 for one cycle, match_count=2, x_min=2, x_max=5, y_min=1, y_max=3.
- Empty frame and first frame: assert rst, run a partial frame, then a VS edge. Required: no stats_valid pulse. Then a full frame with zero matches. Required: stats_valid with count=0 and bbox all 0.
- Mid-frame reset: assert rst for 1 cycle during active video. Required: all outputs 0 the next cycle; thresholds back to INIT; stats unchanged at 0.
